// File: rtl/mem_port_arbiter.sv
// Multi-port to single-port memory arbiter: picks one requesting port, latches its command,
// and holds the downstream request until the memory responds.
module mem_port_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RR_MODE    = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             port_read,
  input  logic [NUM_PORTS-1:0]             port_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata,
  output logic [NUM_PORTS-1:0]             port_resp,
  output logic [DATA_WIDTH-1:0]            port_rdata,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [ADDR_WIDTH-1:0]            pmem_address,
  output logic [DATA_WIDTH-1:0]            pmem_wdata,
  input  logic                             pmem_resp,
  input  logic [DATA_WIDTH-1:0]            pmem_rdata,
  output logic                             grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0]     grant_idx
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       ptr_q;
  logic [IdxW-1:0]       winner_q;
  logic                  rd_q, wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [NUM_PORTS-1:0]  req;
  logic [IdxW-1:0]       base;
  logic [IdxW-1:0]       win;
  logic                  win_found;
  logic [IdxW-1:0]       ptr_next;
  logic                  sel_rd, sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  grant;
  logic                  busy;

  assign req  = port_read | port_write;
  assign base = (RR_MODE != 0) ? ptr_q : '0;

  // Rotating search as two passes: ports at/above base first, then the wrapped-around ones.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req[i] && !win_found && (IdxW'(i) >= base)) begin
        win       = IdxW'(i);
        win_found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req[i] && !win_found && (IdxW'(i) < base)) begin
        win       = IdxW'(i);
        win_found = 1'b1;
      end
    end
  end

  assign ptr_next = (win == IdxW'(NUM_PORTS - 1)) ? '0 : win + IdxW'(1);

  always_comb begin
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (IdxW'(i) == win) begin
        sel_rd    = port_read[i];
        // Read wins when both are raised; the write is dropped for this transaction.
        sel_wr    = port_write[i] & ~port_read[i];
        sel_addr  = port_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = port_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign busy  = (state_q == StBusy);
  assign grant = (state_q == StIdle) && win_found;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_found) state_d = StBusy;
      StBusy:  if (pmem_resp) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      winner_q <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        winner_q <= win;
        rd_q     <= sel_rd;
        wr_q     <= sel_wr;
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
        if (RR_MODE != 0) ptr_q <= ptr_next;
      end
    end
  end

  always_comb begin
    pmem_read    = busy & rd_q;
    pmem_write   = busy & wr_q;
    pmem_address = busy ? addr_q : '0;
    pmem_wdata   = busy ? wdata_q : '0;
    grant_valid  = busy;
    grant_idx    = busy ? winner_q : '0;
    port_rdata   = pmem_rdata;
    port_resp    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_resp[i] = busy & pmem_resp & (IdxW'(i) == winner_q);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: 2-port round-robin and fixed-priority instances share
// stimulus; a 4-port round-robin instance covers pointer wrap-around.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two 2-port instances
  logic [1:0]  port_read, port_write;
  logic [31:0] port_address, port_wdata;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;

  logic [1:0]  a_port_resp, b_port_resp;
  logic [15:0] a_port_rdata, b_port_rdata;
  logic        a_pmem_read, a_pmem_write, b_pmem_read, b_pmem_write;
  logic [15:0] a_pmem_address, a_pmem_wdata, b_pmem_address, b_pmem_wdata;
  logic        a_grant_valid, b_grant_valid;
  logic        a_grant_idx, b_grant_idx;

  logic [3:0]  c_read, c_write;
  logic [63:0] c_address, c_wdata;
  logic        c_pmem_resp;
  logic [15:0] c_pmem_rdata;
  logic [3:0]  c_port_resp;
  logic [15:0] c_port_rdata;
  logic        c_pmem_read, c_pmem_write;
  logic [15:0] c_pmem_address, c_pmem_wdata;
  logic        c_grant_valid;
  logic [1:0]  c_grant_idx;

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(16), .RR_MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .port_read(port_read), .port_write(port_write),
    .port_address(port_address), .port_wdata(port_wdata), .port_resp(a_port_resp),
    .port_rdata(a_port_rdata), .pmem_read(a_pmem_read), .pmem_write(a_pmem_write),
    .pmem_address(a_pmem_address), .pmem_wdata(a_pmem_wdata), .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata), .grant_valid(a_grant_valid), .grant_idx(a_grant_idx)
  );

  mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(16), .RR_MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .port_read(port_read), .port_write(port_write),
    .port_address(port_address), .port_wdata(port_wdata), .port_resp(b_port_resp),
    .port_rdata(b_port_rdata), .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
    .pmem_address(b_pmem_address), .pmem_wdata(b_pmem_wdata), .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata), .grant_valid(b_grant_valid), .grant_idx(b_grant_idx)
  );

  mem_port_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(16), .RR_MODE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .port_read(c_read), .port_write(c_write),
    .port_address(c_address), .port_wdata(c_wdata), .port_resp(c_port_resp),
    .port_rdata(c_port_rdata), .pmem_read(c_pmem_read), .pmem_write(c_pmem_write),
    .pmem_address(c_pmem_address), .pmem_wdata(c_pmem_wdata), .pmem_resp(c_pmem_resp),
    .pmem_rdata(c_pmem_rdata), .grant_valid(c_grant_valid), .grant_idx(c_grant_idx)
  );

  typedef struct packed {
    logic [1:0]  resp;
    logic [15:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] resp, input logic [15:0] rdata);
    exp_t e;
    e.resp  = resp;
    e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  // Scoreboard for the round-robin 2-port instance: every response pulse must match the head.
  always @(negedge clk) begin
    if (a_port_resp !== 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {62'd0, a_port_resp}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_resp", {62'd0, a_port_resp}, {62'd0, e.resp});
        chk("sb_rdata", {48'd0, a_port_rdata}, {48'd0, e.rdata});
      end
    end
  end

  initial begin
    port_read = '0; port_write = '0; port_address = '0; port_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    c_read = '0; c_write = '0; c_address = '0; c_wdata = '0;
    c_pmem_resp = 1'b0; c_pmem_rdata = '0;

    // Reset state
    #12;
    chk("rst_pmem_read", a_pmem_read, 0);
    chk("rst_pmem_write", a_pmem_write, 0);
    chk("rst_pmem_address", a_pmem_address, 0);
    chk("rst_grant_valid", a_grant_valid, 0);
    chk("rst_grant_idx", a_grant_idx, 0);
    chk("rst_port_resp", a_port_resp, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read from port 1, response three cycles after the command
    tick();
    port_read = 2'b10;
    port_address[31:16] = 16'h1234;
    @(negedge clk);
    chk("rd_idle_cycle0", a_pmem_read, 0);
    tick();
    @(negedge clk);
    chk("rd_cmd", a_pmem_read, 1);
    chk("rd_addr", a_pmem_address, 16'h1234);
    chk("rd_grant_idx", a_grant_idx, 1);
    chk("rd_grant_valid", a_grant_valid, 1);
    tick();
    @(negedge clk);
    chk("rd_wait_no_resp", a_port_resp, 0);
    tick();
    pmem_resp = 1'b1;
    pmem_rdata = 16'hBEEF;
    push_exp(2'b10, 16'hBEEF);
    @(negedge clk);
    chk("rd_resp_fixed", b_port_resp, 2'b10);
    tick();
    pmem_resp = 1'b0;
    port_read = 2'b00;
    @(negedge clk);
    chk("rd_back_idle", a_grant_valid, 0);

    // Continuous contention: RR alternates, fixed priority sticks to port 0
    tick();
    port_read = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      pmem_resp = 1'b1;
      pmem_rdata = 16'h1000 + 16'(i);
      push_exp((i % 2 == 1) ? 2'b10 : 2'b01, 16'h1000 + 16'(i));
      @(negedge clk);
      chk("rr_grant_idx", a_grant_idx, i % 2);
      chk("fx_grant_idx", b_grant_idx, 0);
      chk("fx_port_resp", b_port_resp, 2'b01);
      tick();
      pmem_resp = 1'b0;
      if (i == 3) port_read = 2'b00;
      @(negedge clk);
      chk("rr_idle_between", a_grant_valid, 0);
    end

    // Write latching: address/data changes during BUSY must not leak through
    tick();
    port_write = 2'b01;
    port_address[15:0] = 16'h0040;
    port_wdata[15:0] = 16'h5A5A;
    tick();
    port_address[15:0] = 16'hFFFF;
    port_wdata[15:0] = 16'h0000;
    @(negedge clk);
    chk("wr_cmd", a_pmem_write, 1);
    chk("wr_no_read", a_pmem_read, 0);
    chk("wr_addr_latched", a_pmem_address, 16'h0040);
    chk("wr_data_latched", a_pmem_wdata, 16'h5A5A);
    tick();
    @(negedge clk);
    chk("wr_addr_held", a_pmem_address, 16'h0040);
    tick();
    pmem_resp = 1'b1;
    pmem_rdata = 16'h0BAD;
    push_exp(2'b01, 16'h0BAD);
    @(negedge clk);
    chk("wr_data_held", a_pmem_wdata, 16'h5A5A);
    tick();
    pmem_resp = 1'b0;
    port_write = 2'b00;

    // Read and write together on port 0 becomes a read
    tick();
    port_read = 2'b01;
    port_write = 2'b01;
    tick();
    @(negedge clk);
    chk("rw_is_read", a_pmem_read, 1);
    chk("rw_write_dropped", a_pmem_write, 0);
    tick();
    pmem_resp = 1'b1;
    pmem_rdata = 16'h7777;
    push_exp(2'b01, 16'h7777);
    tick();
    pmem_resp = 1'b0;
    port_read = 2'b00;
    port_write = 2'b00;

    // Memory response while idle is ignored
    tick();
    pmem_resp = 1'b1;
    pmem_rdata = 16'hDEAD;
    @(negedge clk);
    chk("idle_resp_ignored", a_port_resp, 0);
    tick();
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("idle_resp_no_busy", a_grant_valid, 0);

    // Reset mid-BUSY after a port-0 grant (pointer would be 1 without the reset)
    tick();
    port_read = 2'b01;
    tick();
    @(negedge clk);
    chk("mid_rst_busy", a_pmem_read, 1);
    tick();
    #2;
    rst_n = 1'b0;
    pmem_resp = 1'b1;
    #1;
    chk("mid_rst_pmem_read", a_pmem_read, 0);
    chk("mid_rst_pmem_address", a_pmem_address, 0);
    chk("mid_rst_grant_valid", a_grant_valid, 0);
    chk("mid_rst_port_resp", a_port_resp, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    pmem_resp = 1'b0;
    port_read = 2'b00;
    tick();
    port_read = 2'b11;
    @(negedge clk);
    chk("post_rst_idle", a_grant_valid, 0);
    tick();
    @(negedge clk);
    chk("post_rst_grant_valid", a_grant_valid, 1);
    chk("post_rst_ptr_zero", a_grant_idx, 0);
    tick();
    pmem_resp = 1'b1;
    pmem_rdata = 16'h3C3C;
    push_exp(2'b01, 16'h3C3C);
    tick();
    pmem_resp = 1'b0;
    port_read = 2'b00;

    // Four ports: grant port 1 to move ptr to 2, then ports 1 and 3 contend
    tick();
    c_read = 4'b0010;
    tick();
    c_pmem_resp = 1'b1;
    c_pmem_rdata = 16'hA1A1;
    @(negedge clk);
    chk("p4_first_idx", c_grant_idx, 1);
    chk("p4_first_resp", c_port_resp, 4'b0010);
    chk("p4_rdata", c_port_rdata, 16'hA1A1);
    tick();
    c_pmem_resp = 1'b0;
    c_read = 4'b1010;
    tick();
    c_pmem_resp = 1'b1;
    @(negedge clk);
    chk("p4_wrap_idx", c_grant_idx, 3);
    chk("p4_wrap_resp", c_port_resp, 4'b1000);
    tick();
    c_pmem_resp = 1'b0;
    tick();
    c_pmem_resp = 1'b1;
    @(negedge clk);
    chk("p4_after_wrap_idx", c_grant_idx, 1);
    chk("p4_after_wrap_resp", c_port_resp, 4'b0010);
    tick();
    c_pmem_resp = 1'b0;
    c_read = 4'b0000;

    tick();
    tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requesting ports, legal range 2..8.
REQ-002 Parameter ADDR_WIDTH, default 16: address width of every port and of pmem_address.
REQ-003 Parameter DATA_WIDTH, default 16: data width of every port and of pmem_wdata/pmem_rdata.
REQ-004 Parameter RR_MODE, default 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 port_read  in  NUM_PORTS  per-port read request, held until that port's resp.
REQ-008 port_write  in  NUM_PORTS  per-port write request, held until that port's resp.
REQ-009 port_address  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 port_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data, same slicing as port_address.
REQ-011 port_resp  out  NUM_PORTS  one-cycle completion pulse to the granted port.
REQ-012 port_rdata  out  DATA_WIDTH  read data shared by all ports; valid only with a port_resp bit.
REQ-013 pmem_read / pmem_write  out  1 each  command to the downstream memory.
REQ-014 pmem_address  out  ADDR_WIDTH;  pmem_wdata  out  DATA_WIDTH.
REQ-015 pmem_resp  in  1;  pmem_rdata  in  DATA_WIDTH  downstream completion and read data.
REQ-016 grant_valid  out  1;  grant_idx  out  clog2(NUM_PORTS)  current owner, debug/performance.

Function
REQ-017 FSM has states IDLE and BUSY; request of port i = port_read[i] | port_write[i].
REQ-018 IDLE with no request: stay IDLE; pmem_read, pmem_write, grant_valid, all port_resp = 0.
REQ-019 IDLE with any request: choose winner, at next edge latch winner index, command, address, wdata into internal registers, enter BUSY.
REQ-020 Fixed mode winner: lowest-indexed requesting port.
REQ-021 RR mode winner: first requesting port at or after pointer ptr, searching upward modulo NUM_PORTS; on grant ptr <= (winner+1) mod NUM_PORTS; ptr unchanged when no grant.
REQ-022 Port asserting read and write together is granted as a read; write suppressed for that transaction.
REQ-023 BUSY: pmem_read/pmem_write/pmem_address/pmem_wdata driven only from latched registers; changes or withdrawal on port inputs during BUSY have no effect.
REQ-024 BUSY: grant_valid = 1, grant_idx = latched winner.
REQ-025 BUSY with pmem_resp = 1: port_resp[winner] = 1 combinationally same cycle, other bits 0; port_rdata = pmem_rdata; next state IDLE.
REQ-026 port_rdata = pmem_rdata in all cycles; no register stage.
REQ-027 Latency: request first seen in IDLE at cycle 0 -> pmem command asserted cycle 1; resp at cycle k -> IDLE cycle k+1 -> next command earliest cycle k+2.
REQ-028 Exactly one transaction per grant; pmem_resp in IDLE is ignored, no port_resp.
REQ-029 Requests arriving in BUSY are held by their requesters and arbitrated on return to IDLE; no queueing inside block.
REQ-030 No starvation in RR mode: a continuously requesting port is granted within NUM_PORTS grants.

Reset
REQ-031 rst_n low asynchronously forces: state IDLE, ptr 0, latched command/address/wdata/winner 0, all pmem and port_resp outputs 0, grant_valid 0, grant_idx 0.
REQ-032 Reset during BUSY abandons the transaction immediately; no port_resp issued; first edge after rst_n rises starts in IDLE.

Verification
REQ-033 Single read: port 1 read, addr 0x1234, pmem_resp 3 cycles later with rdata 0xBEEF -> pmem_read=1 addr 0x1234 from cycle 1, port_resp=2'b10 and port_rdata=0xBEEF in resp cycle.
REQ-034 RR contention, NUM_PORTS=2: both ports request continuously, resp after 1 cycle each -> grants alternate 0,1,0,1; fixed mode same stimulus -> port 0 only.
REQ-035 Write latching: port 0 write addr 0x0040 wdata 0x5A5A, requester changes addr to 0xFFFF in BUSY -> pmem_address stays 0x0040, pmem_wdata 0x5A5A until resp.
REQ-036 Read+write both high on port 0 -> pmem_read=1, pmem_write=0.
REQ-037 rst_n pulsed low mid-BUSY -> all pmem outputs 0 same cycle, no port_resp, ptr 0, next request granted normally.
REQ-038 NUM_PORTS=4, RR, ports 1 and 3 requesting, ptr=2 -> port 3 granted, ptr becomes 0, then port 1.
